// File: rtl/motor_ramp.sv
// motor_ramp: slew limiter in front of the PWM motor driver.
// Ramps the driver's speed toward the latest target at STEP per ramp tick
// and forces every stop or reversal through a brake dead time.
module motor_ramp #(
    parameter int RAMP_DIV   = 256,
    parameter int STEP       = 1,
    parameter int DEAD_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_ctl,
    input  logic [7:0] cmd_vel,
    input  logic       estop,
    output logic [1:0] ctl,
    output logic [7:0] vel,
    output logic       at_target
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;
    localparam logic [PW-1:0] PMAX  = PW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DLOAD = DW'(DEAD_TICKS);
    localparam logic [7:0]    STEP8 = 8'(STEP);
    localparam logic [8:0]    STEP9 = 9'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    state_t        state, state_nx;
    state_t        stop_state;
    logic [PW-1:0] pcnt, pcnt_nx;
    logic [DW-1:0] dcnt, dcnt_nx;
    logic [1:0]    tctl, tctl_nx, ctl_nx;
    logic [7:0]    tvel, tvel_nx, vel_nx;
    logic          tick;
    logic [8:0]    vel9, tvel9, up_sum, dn_diff;

    assign tick       = (pcnt == PMAX);
    assign stop_state = (DEAD_TICKS == 0) ? ST_IDLE : ST_DEAD;
    assign vel9       = {1'b0, vel};
    assign tvel9      = {1'b0, tvel};
    assign up_sum     = vel9 + STEP9;
    assign dn_diff    = vel9 - STEP9;

    // Register update for prescaler, target, dead counter, FSM and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pcnt      <= '0;
            dcnt      <= '0;
            tctl      <= 2'b00;
            tvel      <= 8'd0;
            ctl       <= 2'b00;
            vel       <= 8'd0;
            at_target <= 1'b1;
        end else begin
            state     <= state_nx;
            pcnt      <= pcnt_nx;
            dcnt      <= dcnt_nx;
            tctl      <= tctl_nx;
            tvel      <= tvel_nx;
            ctl       <= ctl_nx;
            vel       <= vel_nx;
            at_target <= (state_nx != ST_DEAD) && (ctl_nx == tctl_nx) && (vel_nx == tvel_nx);
        end
    end

    // Next-state logic: estop overrides everything; otherwise the FSM moves
    // only on tick and decisions use the target held before this edge.
    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        ctl_nx   = ctl;
        vel_nx   = vel;
        tctl_nx  = tctl;
        tvel_nx  = tvel;
        pcnt_nx  = tick ? '0 : pcnt + 1'b1;

        if (estop) begin
            ctl_nx   = 2'b00;
            vel_nx   = 8'd0;
            tctl_nx  = 2'b00;
            tvel_nx  = 8'd0;
            dcnt_nx  = DLOAD;
            state_nx = stop_state;
        end else begin
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (tctl != 2'b00) begin
                            ctl_nx   = tctl;
                            vel_nx   = (tvel9 < STEP9) ? tvel : STEP8;
                            state_nx = ST_DRIVE;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end
                    ST_DRIVE: begin
                        if (tctl == ctl) begin
                            // Same direction: approach the target, never past it.
                            if (vel9 < tvel9) begin
                                vel_nx = (up_sum >= tvel9) ? tvel : up_sum[7:0];
                            end else begin
                                vel_nx = (vel9 >= tvel9 + STEP9) ? dn_diff[7:0] : tvel;
                            end
                        end else begin
                            // Brake or reversal: decelerate to zero, then dead time.
                            if (vel9 <= STEP9) begin
                                vel_nx   = 8'd0;
                                ctl_nx   = 2'b00;
                                dcnt_nx  = DLOAD;
                                state_nx = stop_state;
                            end else begin
                                vel_nx = dn_diff[7:0];
                            end
                        end
                    end
                    ST_DEAD: begin
                        dcnt_nx = dcnt - 1'b1;
                        if (dcnt <= DW'(1)) begin
                            state_nx = ST_IDLE;
                        end else begin
                            state_nx = ST_DEAD;
                        end
                    end
                    default: begin
                        ctl_nx   = 2'b00;
                        vel_nx   = 8'd0;
                        state_nx = ST_IDLE;
                    end
                endcase
            end else begin
                state_nx = state;
            end

            // New command is stored on the same edge; illegal direction or
            // zero speed collapses to a brake target.
            if (cmd_valid) begin
                if (((cmd_ctl == 2'b01) || (cmd_ctl == 2'b10)) && (cmd_vel != 8'd0)) begin
                    tctl_nx = cmd_ctl;
                    tvel_nx = cmd_vel;
                end else begin
                    tctl_nx = 2'b00;
                    tvel_nx = 8'd0;
                end
            end else begin
                tctl_nx = tctl;
            end
        end
    end

endmodule

// File: tb/tb_motor_ramp.sv
// Self-checking bench for motor_ramp: tick-aligned vector table, hand
// sequences for estop and mid-ramp reset, then random traffic against a
// behavioural reference model.
module tb_motor_ramp;

    localparam int RAMP_DIV   = 4;
    localparam int STEP       = 16;
    localparam int DEAD_TICKS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_ctl;
    logic [7:0] cmd_vel;
    logic       estop;
    logic [1:0] ctl;
    logic [7:0] vel;
    logic       at_target;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state (no explicit FSM: dead_left > 0 means braking dead time)
    int m_ctl, m_vel, m_tctl, m_tvel, m_dead, m_pc;
    int prev_ctl;

    motor_ramp #(.RAMP_DIV(RAMP_DIV), .STEP(STEP), .DEAD_TICKS(DEAD_TICKS)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ctl(cmd_ctl),
        .cmd_vel(cmd_vel), .estop(estop), .ctl(ctl), .vel(vel), .at_target(at_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] c;
        logic [7:0] s;
        logic [1:0] e_ctl;
        logic [7:0] e_vel;
        logic       e_at;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ctl = 0; m_vel = 0; m_tctl = 0; m_tvel = 0; m_dead = 0; m_pc = 0;
        prev_ctl = 0;
    endtask

    function automatic int model_at();
        return ((m_dead == 0) && (m_ctl == m_tctl) && (m_vel == m_tvel)) ? 1 : 0;
    endfunction

    // Apply one clock edge to the model using the inputs present at that edge.
    task automatic model_edge(input logic v, input logic [1:0] c, input logic [7:0] s, input logic e);
        bit tk;
        tk = (m_pc == RAMP_DIV - 1);
        if (e) begin
            m_vel = 0; m_ctl = 0; m_tctl = 0; m_tvel = 0; m_dead = DEAD_TICKS;
        end else begin
            if (tk) begin
                if (m_dead > 0) m_dead = m_dead - 1;
                else if (m_ctl == 0) begin
                    if (m_tctl != 0) begin
                        m_ctl = m_tctl;
                        m_vel = (m_tvel < STEP) ? m_tvel : STEP;
                    end
                end else if (m_ctl == m_tctl) begin
                    if (m_tvel > m_vel) m_vel = (m_vel + STEP > m_tvel) ? m_tvel : m_vel + STEP;
                    else                m_vel = (m_vel - STEP < m_tvel) ? m_tvel : m_vel - STEP;
                end else begin
                    m_vel = (m_vel - STEP < 0) ? 0 : m_vel - STEP;
                    if (m_vel == 0) begin
                        m_ctl = 0;
                        m_dead = DEAD_TICKS;
                    end
                end
            end
            if (v) begin
                if ((c == 2'b01 || c == 2'b10) && s != 8'd0) begin
                    m_tctl = c; m_tvel = s;
                end else begin
                    m_tctl = 0; m_tvel = 0;
                end
            end
        end
        m_pc = (m_pc + 1) % RAMP_DIV;
    endtask

    // One clock: drive inputs, step the model on the edge, compare 1 time unit later.
    task automatic step(input logic v, input logic [1:0] c, input logic [7:0] s, input logic e);
        cmd_valid = v; cmd_ctl = c; cmd_vel = s; estop = e;
        @(posedge clk);
        model_edge(v, c, s, e);
        #1;
        chk("model_ctl", int'(ctl), m_ctl);
        chk("model_vel", int'(vel), m_vel);
        chk("model_at", int'(at_target), model_at());
        chk("ctl_legal", ((ctl == 2'b11) || (prev_ctl == 1 && ctl == 2'b10) ||
                          (prev_ctl == 2 && ctl == 2'b01)) ? 1 : 0, 0);
        prev_ctl = int'(ctl);
        cmd_valid = 1'b0;
    endtask

    task automatic add(input logic v, input logic [1:0] c, input logic [7:0] s,
                       input logic [1:0] ec, input logic [7:0] ev, input logic ea);
        vec_t t;
        t.v = v; t.c = c; t.s = s; t.e_ctl = ec; t.e_vel = ev; t.e_at = ea;
        tbl.push_back(t);
    endtask

    initial begin
        // Each entry: optional command on the first cycle, then run to the next tick.
        add(1, 2'b01, 8'd100, 2'b01, 8'd16, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd32, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd48, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd64, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd80, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd96, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd100, 1);
        add(1, 2'b01, 8'd40,  2'b01, 8'd84, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd68, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd52, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd40, 1);
        add(1, 2'b01, 8'd100, 2'b01, 8'd56, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd72, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd88, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd100, 1);
        add(1, 2'b10, 8'd50,  2'b01, 8'd84, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd68, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd52, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd36, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd20, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd4, 0);
        add(0, 2'b00, 8'd0,   2'b00, 8'd0, 0);
        add(0, 2'b00, 8'd0,   2'b00, 8'd0, 0);
        add(0, 2'b00, 8'd0,   2'b00, 8'd0, 0);
        add(0, 2'b00, 8'd0,   2'b10, 8'd16, 0);
        add(0, 2'b00, 8'd0,   2'b10, 8'd32, 0);
        add(0, 2'b00, 8'd0,   2'b10, 8'd48, 0);
        add(0, 2'b00, 8'd0,   2'b10, 8'd50, 1);
        add(1, 2'b11, 8'd200, 2'b10, 8'd34, 0);
        add(0, 2'b00, 8'd0,   2'b10, 8'd18, 0);
        add(0, 2'b00, 8'd0,   2'b10, 8'd2, 0);
        add(0, 2'b00, 8'd0,   2'b00, 8'd0, 0);
        add(0, 2'b00, 8'd0,   2'b00, 8'd0, 0);
        add(0, 2'b00, 8'd0,   2'b00, 8'd0, 1);
        add(1, 2'b01, 8'd40,  2'b01, 8'd16, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd32, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd40, 1);
        add(1, 2'b01, 8'd0,   2'b01, 8'd24, 0);
        add(0, 2'b00, 8'd0,   2'b01, 8'd8, 0);
        add(0, 2'b00, 8'd0,   2'b00, 8'd0, 0);
        add(0, 2'b00, 8'd0,   2'b00, 8'd0, 0);
        add(0, 2'b00, 8'd0,   2'b00, 8'd0, 1);

        rst = 1'b1; cmd_valid = 1'b0; cmd_ctl = 2'b00; cmd_vel = 8'd0; estop = 1'b0;
        model_reset();
        #1;
        chk("reset_ctl", int'(ctl), 0);
        chk("reset_vel", int'(vel), 0);
        chk("reset_at", int'(at_target), 1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].c, tbl[i].s, 1'b0);
            for (int k = 1; k < RAMP_DIV; k++) step(1'b0, 2'b00, 8'd0, 1'b0);
            chk($sformatf("vec%0d_ctl", i), int'(ctl), int'(tbl[i].e_ctl));
            chk($sformatf("vec%0d_vel", i), int'(vel), int'(tbl[i].e_vel));
            chk($sformatf("vec%0d_at", i), int'(at_target), int'(tbl[i].e_at));
        end

        // estop mid-ramp at fwd/64 with a command that must be ignored
        step(1'b1, 2'b01, 8'd100, 1'b0);
        for (int k = 1; k < 4 * RAMP_DIV; k++) step(1'b0, 2'b00, 8'd0, 1'b0);
        chk("estop_pre_vel", int'(vel), 64);
        step(1'b1, 2'b01, 8'd30, 1'b1);
        chk("estop_ctl", int'(ctl), 0);
        chk("estop_vel", int'(vel), 0);
        chk("estop_at", int'(at_target), 0);
        for (int k = 0; k < 2 * RAMP_DIV; k++) step(1'b0, 2'b00, 8'd0, 1'b0);
        chk("estop_after_at", int'(at_target), 1);
        chk("estop_after_ctl", int'(ctl), 0);
        chk("estop_after_vel", int'(vel), 0);

        // Asynchronous reset between edges in the middle of a ramp
        step(1'b1, 2'b01, 8'd100, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 2'b00, 8'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("areset_ctl", int'(ctl), 0);
        chk("areset_vel", int'(vel), 0);
        chk("areset_at", int'(at_target), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        step(1'b1, 2'b01, 8'd100, 1'b0);
        step(1'b0, 2'b00, 8'd0, 1'b0);
        step(1'b0, 2'b00, 8'd0, 1'b0);
        chk("first_tick_e3_ctl", int'(ctl), 0);
        step(1'b0, 2'b00, 8'd0, 1'b0);
        chk("first_tick_e4_ctl", int'(ctl), 1);
        chk("first_tick_e4_vel", int'(vel), 16);

        // Random traffic against the reference model
        for (int k = 0; k < 800; k++) begin
            logic       rv, re;
            logic [1:0] rc;
            logic [7:0] rs;
            rv = ($urandom_range(0, 9) == 0);
            re = ($urandom_range(0, 99) == 0);
            rc = 2'($urandom_range(0, 3));
            rs = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            step(rv, rc, rs, re);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
